// File: rtl/fabric_cfg_pkg.sv
// Shared constants, header field positions and FSM state encoding for the config frame loader.
package fabric_cfg_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 8;

  localparam logic [WORD_W-1:0] SYNC_WORD = 32'hFAB0_FAB1;

  localparam int unsigned END_BIT = 31;
  localparam int unsigned COL_MSB = 15;
  localparam int unsigned COL_LSB = 8;
  localparam int unsigned FRM_MSB = 7;
  localparam int unsigned FRM_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    STROBE,
    HOLD,
    CHK
  } cfg_state_e;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Combinational (col, frame, en) -> one-hot latch enable, bit col*MAX_FRAMES+frame.
module frame_strobe_decoder
  import fabric_cfg_pkg::*;
#(
  parameter int unsigned NUM_COLUMNS = 4,
  parameter int unsigned MAX_FRAMES  = 20
) (
  input  logic [IDX_W-1:0]                    col,
  input  logic [IDX_W-1:0]                    frame,
  input  logic                                en,
  output logic [NUM_COLUMNS*MAX_FRAMES-1:0]   strobe_c
);

  // Each output bit matches exactly one (column, frame) pair, so the result is one-hot or zero.
  for (genvar i = 0; i < NUM_COLUMNS * MAX_FRAMES; i++) begin : g_bit
    assign strobe_c[i] = en
                       && (col   == IDX_W'(i / MAX_FRAMES))
                       && (frame == IDX_W'(i % MAX_FRAMES));
  end

endmodule

// File: rtl/config_frame_loader.sv
// Config frame loader: SYNC/header/data word stream -> FrameData + one-hot FrameStrobe pulses.
// Optional trailing checksum word enabled by defining CFG_CHECKSUM_EN.
module config_frame_loader
  import fabric_cfg_pkg::*;
#(
  parameter int unsigned NUM_ROWS      = 4,
  parameter int unsigned NUM_COLUMNS   = 4,
  parameter int unsigned MAX_FRAMES    = 20,
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic [WORD_W-1:0]                   s_data,
  input  logic                                s_valid,
  output logic                                s_ready,
  output logic [NUM_ROWS*WORD_W-1:0]          FrameData,
  output logic [NUM_COLUMNS*MAX_FRAMES-1:0]   FrameStrobe,
  output logic                                cfg_busy,
  output logic                                cfg_done,
  output logic                                cfg_error
);

  localparam int unsigned ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int unsigned STRB_W = $clog2(STROBE_CYCLES) + 1;

  cfg_state_e               state_q;
  logic [IDX_W-1:0]         col_q;
  logic [IDX_W-1:0]         frm_q;
  logic                     frame_ok_q;
  logic [ROW_W-1:0]         row_cnt_q;
  logic [STRB_W-1:0]        strb_cnt_q;
`ifdef CFG_CHECKSUM_EN
  logic [WORD_W-1:0]        sum_q;
`endif

  logic                                hs_c;
  logic                                hdr_ok_c;
  logic [NUM_COLUMNS*MAX_FRAMES-1:0]   strobe_dec_c;

  // Word transfer and header range check.
  assign hs_c     = s_valid & s_ready;
  assign hdr_ok_c = (32'(s_data[COL_MSB:COL_LSB]) < NUM_COLUMNS)
                 && (32'(s_data[FRM_MSB:FRM_LSB]) < MAX_FRAMES);

  // Decode the latched target of the current frame.
  frame_strobe_decoder #(
    .NUM_COLUMNS (NUM_COLUMNS),
    .MAX_FRAMES  (MAX_FRAMES)
  ) u_dec (
    .col      (col_q),
    .frame    (frm_q),
    .en       (frame_ok_q),
    .strobe_c (strobe_dec_c)
  );

  // Session FSM with counters, frame data registers and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      col_q       <= '0;
      frm_q       <= '0;
      frame_ok_q  <= 1'b0;
      row_cnt_q   <= '0;
      strb_cnt_q  <= '0;
      s_ready     <= 1'b0;
      FrameData   <= '0;
      FrameStrobe <= '0;
      cfg_busy    <= 1'b0;
      cfg_done    <= 1'b0;
      cfg_error   <= 1'b0;
`ifdef CFG_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      cfg_done <= 1'b0;
      case (state_q)
        IDLE: begin
          s_ready <= 1'b1;
          if (hs_c && (s_data == SYNC_WORD)) begin
            cfg_error <= 1'b0;
            cfg_busy  <= 1'b1;
            state_q   <= HDR;
`ifdef CFG_CHECKSUM_EN
            sum_q     <= '0;
`endif
          end
        end
        HDR: begin
          if (hs_c) begin
            if (s_data[END_BIT]) begin
`ifdef CFG_CHECKSUM_EN
              state_q  <= CHK;
`else
              cfg_done <= 1'b1;
              cfg_busy <= 1'b0;
              state_q  <= IDLE;
`endif
            end else begin
              col_q      <= s_data[COL_MSB:COL_LSB];
              frm_q      <= s_data[FRM_MSB:FRM_LSB];
              frame_ok_q <= hdr_ok_c;
              row_cnt_q  <= '0;
              state_q    <= DATA;
              if (!hdr_ok_c) cfg_error <= 1'b1;
            end
          end
        end
        DATA: begin
          if (hs_c) begin
            if (frame_ok_q) begin
              for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                if (row_cnt_q == ROW_W'(r)) FrameData[r*WORD_W +: WORD_W] <= s_data;
              end
            end
`ifdef CFG_CHECKSUM_EN
            sum_q <= sum_q + s_data;
`endif
            if (row_cnt_q == ROW_W'(NUM_ROWS - 1)) begin
              if (frame_ok_q) begin
                FrameStrobe <= strobe_dec_c;
                strb_cnt_q  <= '0;
                s_ready     <= 1'b0;
                state_q     <= STROBE;
              end else begin
                state_q     <= HDR;
              end
            end else begin
              row_cnt_q <= row_cnt_q + 1'b1;
            end
          end
        end
        STROBE: begin
          if (strb_cnt_q == STRB_W'(STROBE_CYCLES - 1)) begin
            FrameStrobe <= '0;
            state_q     <= HOLD;
          end else begin
            strb_cnt_q  <= strb_cnt_q + 1'b1;
          end
        end
        HOLD: begin
          s_ready <= 1'b1;
          state_q <= HDR;
        end
`ifdef CFG_CHECKSUM_EN
        CHK: begin
          if (hs_c) begin
            if (s_data != sum_q) cfg_error <= 1'b1;
            cfg_done <= 1'b1;
            cfg_busy <= 1'b0;
            state_q  <= IDLE;
          end
        end
`endif
        default: begin
          FrameStrobe <= '0;
          cfg_busy    <= 1'b0;
          s_ready     <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_frame_loader.sv
// Self-checking bench for config_frame_loader: directed scenarios plus randomized sessions
// checked against a frame-level reference model.
module tb_config_frame_loader;

  localparam int unsigned NR = 4;
  localparam int unsigned NC = 4;
  localparam int unsigned MF = 20;
  localparam int unsigned SC = 2;
  localparam int unsigned DW = NR * 32;
  localparam int unsigned SW = NC * MF;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [31:0]   s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] FrameData;
  logic [SW-1:0] FrameStrobe;
  logic          cfg_busy;
  logic          cfg_done;
  logic          cfg_error;

  config_frame_loader #(
    .NUM_ROWS      (NR),
    .NUM_COLUMNS   (NC),
    .MAX_FRAMES    (MF),
    .STROBE_CYCLES (SC)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .cfg_busy    (cfg_busy),
    .cfg_done    (cfg_done),
    .cfg_error   (cfg_error)
  );

  always #5 CLK = ~CLK;

  int errs   = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: frame contents, expected strobe events, error flag, sum and done count.
  logic [31:0] exp_rows [NR];
  int          exp_idx [$];
  int          exp_len [$];
  logic        exp_err  = 1'b0;
  logic [31:0] exp_sum  = '0;
  int          exp_done = 0;

  function automatic logic [DW-1:0] exp_data();
    logic [DW-1:0] v;
    v = '0;
    for (int r = 0; r < NR; r++) v[r*32 +: 32] = exp_rows[r];
    return v;
  endfunction

  // Observation: strobe pulses (index, length), cfg_done pulses, per-cycle invariants.
  int            obs_idx [$];
  int            obs_len [$];
  int            done_cnt = 0;
  int            run      = 0;
  int            cur_idx  = 0;
  logic [SW-1:0] prev_strobe = '0;
  logic [DW-1:0] prev_data   = '0;
  logic          prev_rst    = 1'b1;

  always @(negedge CLK) begin
    check("onehot0", 128'($onehot0(FrameStrobe)), 128'(1'b1));
    if (prev_strobe != '0 && !prev_rst && !RST)
      check("data_stable_while_strobe", 128'(FrameData), 128'(prev_data));
    if (prev_strobe != '0 && FrameStrobe != prev_strobe) begin
      obs_idx.push_back(cur_idx);
      obs_len.push_back(run);
    end
    if (FrameStrobe != '0) begin
      if (FrameStrobe == prev_strobe) run++;
      else begin
        run = 1;
        for (int i = 0; i < SW; i++) if (FrameStrobe[i]) cur_idx = i;
      end
    end
    if (cfg_done) done_cnt++;
    prev_strobe = FrameStrobe;
    prev_data   = FrameData;
    prev_rst    = RST;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Present one word after 'gap' idle cycles; returns #1 after its handshake edge.
  task automatic send(input logic [31:0] w, input int gap);
    int n;
    s_valid = 1'b0;
    repeat (gap) begin @(posedge CLK); #1; end
    s_data  = w;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 50) begin @(posedge CLK); #1; n++; end
    if (n >= 50) check("ready_timeout", 128'(s_ready), 128'(1'b1));
    @(posedge CLK); #1;
    s_valid = 1'b0;
  endtask

  task automatic start_session();
    send(SYNC, 0);
    exp_err = 1'b0;
    exp_sum = '0;
  endtask

  // Header plus NR data words; the model decides validity from the header fields.
  task automatic model_frame(input int col, input int frm, input int maxgap);
    logic [31:0] w;
    logic        ok;
    ok = (col < NC) && (frm < MF);
    send({1'b0, 15'($urandom), 8'(col), 8'(frm)}, $urandom_range(0, maxgap));
    if (!ok) exp_err = 1'b1;
    for (int k = 0; k < NR; k++) begin
      w = $urandom;
      send(w, $urandom_range(0, maxgap));
      exp_sum = exp_sum + w;
      if (ok) exp_rows[k] = w;
    end
    if (ok) begin
      exp_idx.push_back(col * MF + frm);
      exp_len.push_back(SC);
    end
  endtask

  task automatic end_session(input bit bad);
    send({1'b1, 31'($urandom)}, 0);
`ifdef CFG_CHECKSUM_EN
    send(bad ? exp_sum + 32'd1 : exp_sum, 0);
    if (bad) exp_err = 1'b1;
`else
    if (bad) exp_err = exp_err;
`endif
    exp_done++;
  endtask

  task automatic check_all(input string tag);
    repeat (2) begin @(posedge CLK); #1; end
    check({tag, "_data"},  128'(FrameData), 128'(exp_data()));
    check({tag, "_error"}, 128'(cfg_error), 128'(exp_err));
    check({tag, "_busy"},  128'(cfg_busy),  128'(1'b0));
    check({tag, "_done"},  128'(done_cnt),  128'(exp_done));
    check({tag, "_nstrobes"}, 128'(obs_idx.size()), 128'(exp_idx.size()));
    for (int i = 0; i < exp_idx.size() && i < obs_idx.size(); i++) begin
      check($sformatf("%s_strobe_idx%0d", tag, i), 128'(obs_idx[i]), 128'(exp_idx[i]));
      check($sformatf("%s_strobe_len%0d", tag, i), 128'(obs_len[i]), 128'(exp_len[i]));
    end
    obs_idx.delete(); obs_len.delete();
    exp_idx.delete(); exp_len.delete();
  endtask

  initial begin
    logic [SW-1:0] bit_v;
    logic [31:0]   w;
    int            nf;
    for (int r = 0; r < NR; r++) exp_rows[r] = '0;

    // Reset state
    RST = 1'b1;
    repeat (2) begin @(posedge CLK); #1; end
    check("rst_data",   128'(FrameData),   128'(0));
    check("rst_strobe", 128'(FrameStrobe), 128'(0));
    check("rst_busy",   128'(cfg_busy),    128'(1'b0));
    check("rst_done",   128'(cfg_done),    128'(1'b0));
    check("rst_error",  128'(cfg_error),   128'(1'b0));
    check("rst_ready",  128'(s_ready),     128'(1'b0));
    RST = 1'b0;
    @(posedge CLK); #1;
    check("idle_ready", 128'(s_ready), 128'(1'b1));

    // Test 2 first: garbage before SYNC is ignored
    send(32'hDEAD_BEEF, 0);
    check("t2_busy_garbage", 128'(cfg_busy), 128'(1'b0));
    send(32'h1234_5678, 1);
    check("t2_busy_garbage2", 128'(cfg_busy), 128'(1'b0));
    check("done_none", 128'(done_cnt), 128'(0));

    // Test 1: single frame to column 1 frame 3 with exact strobe timing
    start_session();
    check("t1_busy_after_sync", 128'(cfg_busy), 128'(1'b1));
    send(32'h0000_0103, 0);
    send(32'h1111_1111, 0);
    send(32'h2222_2222, 0);
    send(32'h3333_3333, 0);
    send(32'h4444_4444, 0);
    exp_rows[0] = 32'h1111_1111; exp_rows[1] = 32'h2222_2222;
    exp_rows[2] = 32'h3333_3333; exp_rows[3] = 32'h4444_4444;
    exp_sum = 32'hAAAA_AAAA;
    exp_idx.push_back(23); exp_len.push_back(SC);
    bit_v = '0; bit_v[23] = 1'b1;
    check("t1_strobe_c1", 128'(FrameStrobe), 128'(bit_v));
    check("t1_ready_c1",  128'(s_ready),     128'(1'b0));
    check("t1_data",      128'(FrameData),   128'(128'h44444444_33333333_22222222_11111111));
    @(posedge CLK); #1;
    check("t1_strobe_c2", 128'(FrameStrobe), 128'(bit_v));
    @(posedge CLK); #1;
    check("t1_strobe_hold", 128'(FrameStrobe), 128'(0));
    check("t1_ready_hold",  128'(s_ready),     128'(1'b0));
    check("t1_busy_hold",   128'(cfg_busy),    128'(1'b1));
    @(posedge CLK); #1;
    check("t1_ready_hdr",   128'(s_ready),     128'(1'b1));
    send(32'h8000_0000, 0);
`ifdef CFG_CHECKSUM_EN
    check("t1_done_before_chk", 128'(cfg_done), 128'(1'b0));
    send(32'hAAAA_AAAA, 0);
`endif
    check("t1_done_pulse", 128'(cfg_done), 128'(1'b1));
    exp_done++;
    check_all("t1");

    // Test 3: out-of-range column is consumed without write or strobe
    start_session();
    send(32'h0000_0500, 0);
    for (int k = 0; k < NR; k++) begin
      w = $urandom;
      send(w, 0);
      exp_sum = exp_sum + w;
    end
    exp_err = 1'b1;
    check("t3_error",  128'(cfg_error),   128'(1'b1));
    check("t3_strobe", 128'(FrameStrobe), 128'(0));
    check("t3_data",   128'(FrameData),   128'(exp_data()));
    model_frame(2, 7, 0);
    end_session(1'b0);
    check_all("t3");

    // Test 4: valid gap between D1 and D2
    start_session();
    send(32'h0000_0000, 0);
    send(32'hA0A0_0000, 0);
    send(32'hA1A1_0001, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check("t4_ready_gap",  128'(s_ready),     128'(1'b1));
      check("t4_strobe_gap", 128'(FrameStrobe), 128'(0));
    end
    send(32'hA2A2_0002, 0);
    check("t4_strobe_d2", 128'(FrameStrobe), 128'(0));
    send(32'hA3A3_0003, 0);
    bit_v = '0; bit_v[0] = 1'b1;
    check("t4_strobe_d3", 128'(FrameStrobe), 128'(bit_v));
    exp_rows[0] = 32'hA0A0_0000; exp_rows[1] = 32'hA1A1_0001;
    exp_rows[2] = 32'hA2A2_0002; exp_rows[3] = 32'hA3A3_0003;
    exp_sum = 32'hA0A0_0000 + 32'hA1A1_0001 + 32'hA2A2_0002 + 32'hA3A3_0003;
    exp_idx.push_back(0); exp_len.push_back(SC);
    end_session(1'b0);
    check_all("t4");

    // Test 5: reset during the first strobe cycle
    start_session();
    send(32'h0000_0313, 0);
    for (int k = 0; k < NR; k++) send($urandom, 0);
    bit_v = '0; bit_v[79] = 1'b1;
    check("t5_strobe_pre", 128'(FrameStrobe), 128'(bit_v));
    RST = 1'b1;
    @(posedge CLK); #1;
    check("t5_strobe_rst", 128'(FrameStrobe), 128'(0));
    check("t5_data_rst",   128'(FrameData),   128'(0));
    check("t5_busy_rst",   128'(cfg_busy),    128'(1'b0));
    check("t5_ready_rst",  128'(s_ready),     128'(1'b0));
    RST = 1'b0;
    @(posedge CLK); #1;
    check("t5_ready_post", 128'(s_ready),  128'(1'b1));
    check("t5_busy_post",  128'(cfg_busy), 128'(1'b0));
    @(posedge CLK); #1;
    for (int r = 0; r < NR; r++) exp_rows[r] = '0;
    obs_idx.delete(); obs_len.delete();
    exp_err = 1'b0;
    start_session();
    model_frame(3, 19, 1);
    end_session(1'b0);
    check_all("t5");

    // Test 6: wrong trailing checksum word (flags an error only with the checksum feature)
    start_session();
    model_frame(1, 3, 0);
    end_session(1'b1);
    check_all("t6");

    // Randomized sessions
    for (int s = 0; s < 12; s++) begin
      if ($urandom_range(0, 1) == 1) begin
        w = $urandom;
        if (w == SYNC) w = w ^ 32'h1;
        send(w, $urandom_range(0, 2));
      end
      start_session();
      nf = $urandom_range(1, 4);
      for (int f = 0; f < nf; f++)
        model_frame($urandom_range(0, 5), $urandom_range(0, 23), 2);
      end_session($urandom_range(0, 3) == 0);
      check_all($sformatf("rnd%0d", s));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
